// File: rtl/etx_gearbox.sv
// ---------------------------------------------------------------------------
// etx_gearbox
//
// Transmit gearbox for the eLink TX path. Wide words (PW bits, plus one frame
// bit per NW-bit slice) are accepted over a valid/ready handshake and emitted
// as a gapless stream of NW-bit slices, one per clock, each with its frame
// bit. All outputs toward the pads are registered so they can feed DDR output
// flops directly. The block also conditions the raw pushback input from the
// pad buffer: a two-flop synchronizer, optional polarity inversion and a
// minimum-width stretch. Optionally, the stretched wait blocks acceptance of
// the next word.
//
// Parameters
//   PW       input word width, an integer multiple of NW
//   NW       output slice width
//   R        slices per word (PW/NW), at least 2
//   WAITHOLD minimum wait_out pulse width in cycles, at least 1
//   INVERT   1 = board pins are inverted: out_data, out_frame and wait_in are
//            XORed with 1
//   STALL    1 = in_ready is held low while wait_out is high
//
// Ports
//   clk        in   1   fast transmit clock
//   nreset     in   1   synchronous, active-low reset
//   in_valid   in   1   in_data / in_frame valid
//   in_data    in   PW  word; slice i = in_data[i*NW +: NW]
//   in_frame   in   R   in_frame[i] accompanies slice i
//   in_ready   out  1   word accepted when in_valid & in_ready at rising clk
//   out_data   out  NW  registered slice (polarity applied)
//   out_frame  out  1   registered frame bit (polarity applied)
//   out_busy   out  1   registered; high while out_data carries a slice
//   wait_in    in   1   raw asynchronous pushback
//   wait_out   out  1   synchronized, stretched pushback
// ---------------------------------------------------------------------------
module etx_gearbox #(
    parameter int PW       = 64,
    parameter int NW       = 16,
    parameter int R        = PW / NW,
    parameter int WAITHOLD = 2,
    parameter int INVERT   = 0,
    parameter int STALL    = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    input  logic [R-1:0]  in_frame,
    output logic          in_ready,
    output logic [NW-1:0] out_data,
    output logic          out_frame,
    output logic          out_busy,
    input  logic          wait_in,
    output logic          wait_out
);

    // Counter width; kept at least one bit so degenerate parameter sets
    // still elaborate.
    localparam int              CW        = (R > 1) ? $clog2(R) : 1;
    localparam logic            INV       = (INVERT != 0);
    localparam logic            STL       = (STALL != 0);
    localparam logic [NW-1:0]   IDLE_DATA = {NW{INV}};
    localparam logic [CW-1:0]   LAST_CNT  = CW'(R - 1);

    // -----------------------------------------------------------------------
    // Serializer state
    // -----------------------------------------------------------------------
    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_data;
    logic [R-1:0]    r_frame;
    logic [NW-1:0]   r_out_data;
    logic            r_out_frame;

    logic            w_busy_next;
    logic [CW-1:0]   w_cnt_next;
    logic [PW-1:0]   w_data_next;
    logic [R-1:0]    w_frame_next;
    logic [NW-1:0]   w_out_data_next;
    logic            w_out_frame_next;

    logic            w_last;
    logic            w_accept;
    logic [CW-1:0]   w_cnt_inc;
    logic [NW-1:0]   w_slice [R];

    // -----------------------------------------------------------------------
    // Wait conditioning state
    // -----------------------------------------------------------------------
    logic                r_s1;
    logic                r_s2;
    logic [WAITHOLD-1:0] r_hist;

    // Break the held word into addressable slices.
    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_slice
            assign w_slice[gi] = r_data[gi*NW +: NW];
        end
    endgenerate

    // The final slice of a word is on the output while cnt sits at R-1.
    assign w_last    = r_busy && (r_cnt == LAST_CNT);
    assign w_cnt_inc = r_cnt + CW'(1);

    // Accepting on the final-slice cycle lets the next word's slice 0 follow
    // without a bubble. The stall gate only affects this handshake; a word
    // already in flight always runs to completion.
    assign in_ready  = (~r_busy | w_last) & ~(STL & wait_out);
    assign w_accept  = in_valid & in_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_frame     <= '0;
            r_out_data  <= IDLE_DATA;
            r_out_frame <= INV;
        end else begin
            r_busy      <= w_busy_next;
            r_cnt       <= w_cnt_next;
            r_data      <= w_data_next;
            r_frame     <= w_frame_next;
            r_out_data  <= w_out_data_next;
            r_out_frame <= w_out_frame_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_busy_next  = r_busy;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        w_frame_next = r_frame;

        if (w_accept) begin
            w_busy_next  = 1'b1;
            w_cnt_next   = '0;
            w_data_next  = in_data;
            w_frame_next = in_frame;
        end else if (r_busy) begin
            if (w_last) begin
                // Word finished and nothing new offered: drop to idle.
                w_busy_next = 1'b0;
                w_cnt_next  = '0;
            end else begin
                w_cnt_next  = w_cnt_inc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output logic (values loaded into the output registers)
    // -----------------------------------------------------------------------
    always_comb begin
        w_out_data_next  = IDLE_DATA;
        w_out_frame_next = INV;

        if (w_accept) begin
            // Slice 0 comes straight from the input so it appears on the
            // same edge that captures the word.
            w_out_data_next  = in_data[NW-1:0] ^ IDLE_DATA;
            w_out_frame_next = in_frame[0] ^ INV;
        end else if (r_busy && !w_last) begin
            w_out_data_next  = w_slice[w_cnt_inc] ^ IDLE_DATA;
            w_out_frame_next = r_frame[w_cnt_inc] ^ INV;
        end
    end

    assign out_data  = r_out_data;
    assign out_frame = r_out_frame;
    // r_busy is itself a register and is high exactly while a slice is out.
    assign out_busy  = r_busy;

    // -----------------------------------------------------------------------
    // Wait path: two-flop synchronizer, polarity fix, then a history shift
    // register whose OR stretches every pulse by WAITHOLD-1 cycles.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= wait_in;
            r_s2 <= r_s1;
        end
    end

    generate
        if (WAITHOLD == 1) begin : g_hist_single
            always_ff @(posedge clk) begin
                if (!nreset) begin
                    r_hist <= '0;
                end else begin
                    r_hist <= r_s2 ^ INV;
                end
            end
        end else begin : g_hist_shift
            always_ff @(posedge clk) begin
                if (!nreset) begin
                    r_hist <= '0;
                end else begin
                    r_hist <= {r_hist[WAITHOLD-2:0], r_s2 ^ INV};
                end
            end
        end
    endgenerate

    assign wait_out = |r_hist;

endmodule

// File: tb/tb_etx_gearbox.sv
module tb_etx_gearbox;

    localparam int PW = 64;
    localparam int NW = 16;
    localparam int R  = 4;

    logic clk = 1'b0;
    logic nreset;

    // Main instance: INVERT=0, STALL=0, WAITHOLD=2
    logic          m_valid;
    logic [PW-1:0] m_data;
    logic [R-1:0]  m_frame;
    logic          m_ready;
    logic [NW-1:0] m_odata;
    logic          m_oframe;
    logic          m_obusy;
    logic          m_wait_in;
    logic          m_wait_out;

    // Inverted-pin instance: INVERT=1
    logic          v_valid;
    logic [PW-1:0] v_data;
    logic [R-1:0]  v_frame;
    logic          v_ready;
    logic [NW-1:0] v_odata;
    logic          v_oframe;
    logic          v_obusy;
    logic          v_wait_in;
    logic          v_wait_out;

    // Stalling instance: STALL=1
    logic          s_valid;
    logic [PW-1:0] s_data;
    logic [R-1:0]  s_frame;
    logic          s_ready;
    logic [NW-1:0] s_odata;
    logic          s_oframe;
    logic          s_obusy;
    logic          s_wait_in;
    logic          s_wait_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    etx_gearbox #(.PW(PW), .NW(NW), .WAITHOLD(2), .INVERT(0), .STALL(0)) u_dut (
        .clk(clk), .nreset(nreset),
        .in_valid(m_valid), .in_data(m_data), .in_frame(m_frame), .in_ready(m_ready),
        .out_data(m_odata), .out_frame(m_oframe), .out_busy(m_obusy),
        .wait_in(m_wait_in), .wait_out(m_wait_out)
    );

    etx_gearbox #(.PW(PW), .NW(NW), .WAITHOLD(2), .INVERT(1), .STALL(0)) u_inv (
        .clk(clk), .nreset(nreset),
        .in_valid(v_valid), .in_data(v_data), .in_frame(v_frame), .in_ready(v_ready),
        .out_data(v_odata), .out_frame(v_oframe), .out_busy(v_obusy),
        .wait_in(v_wait_in), .wait_out(v_wait_out)
    );

    etx_gearbox #(.PW(PW), .NW(NW), .WAITHOLD(2), .INVERT(0), .STALL(1)) u_stall (
        .clk(clk), .nreset(nreset),
        .in_valid(s_valid), .in_data(s_data), .in_frame(s_frame), .in_ready(s_ready),
        .out_data(s_odata), .out_frame(s_oframe), .out_busy(s_obusy),
        .wait_in(s_wait_in), .wait_out(s_wait_out)
    );

    typedef struct {
        logic          valid;
        logic [PW-1:0] data;
        logic [R-1:0]  frame;
        logic [NW-1:0] e_data;
        logic          e_frame;
        logic          e_busy;
        logic          e_ready;
    } vec_t;

    typedef struct {
        logic          wait_in;
        logic          valid;
        logic [PW-1:0] data;
        logic [NW-1:0] e_data;
        logic          e_busy;
        logic          e_ready;
        logic          e_wait;
    } stall_t;

    vec_t   tbl[$];
    stall_t stl[$];

    function automatic vec_t mk(input logic v, input logic [PW-1:0] d, input logic [R-1:0] f,
                                input logic [NW-1:0] ed, input logic ef, input logic eb,
                                input logic er);
        vec_t t;
        t.valid = v; t.data = d; t.frame = f;
        t.e_data = ed; t.e_frame = ef; t.e_busy = eb; t.e_ready = er;
        return t;
    endfunction

    function automatic stall_t mks(input logic w, input logic v, input logic [PW-1:0] d,
                                   input logic [NW-1:0] ed, input logic eb, input logic er,
                                   input logic ew);
        stall_t t;
        t.wait_in = w; t.valid = v; t.data = d;
        t.e_data = ed; t.e_busy = eb; t.e_ready = er; t.e_wait = ew;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock: inputs were driven at the previous falling edge; outputs
    // are sampled at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_main(input string tag, input logic [NW-1:0] ed, input logic ef,
                            input logic eb, input logic er);
        chk({tag, " out_data"},  64'(m_odata),  64'(ed));
        chk({tag, " out_frame"}, 64'(m_oframe), 64'(ef));
        chk({tag, " out_busy"},  64'(m_obusy),  64'(eb));
        chk({tag, " in_ready"},  64'(m_ready),  64'(er));
        $display("%s: data=%h frame=%0b busy=%0b ready=%0b", tag, m_odata, m_oframe, m_obusy, m_ready);
    endtask

    localparam logic [PW-1:0] WS = 64'h4444_3333_2222_1111;
    localparam logic [PW-1:0] WA = 64'hA3A3_A2A2_A1A1_A0A0;
    localparam logic [PW-1:0] WB = 64'hB3B3_B2B2_B1B1_B0B0;
    localparam logic [PW-1:0] WC = 64'hC3C3_C2C2_C1C1_C0C0;
    localparam logic [PW-1:0] WD = 64'h8001_4002_2004_1008;
    localparam logic [PW-1:0] WE = 64'hFFFF_0000_FFFF_0000;
    localparam logic [PW-1:0] W0 = 64'hD3D3_D2D2_D1D1_D0D0;
    localparam logic [PW-1:0] W1 = 64'hE3E3_E2E2_E1E1_E0E0;
    localparam logic [PW-1:0] WX = 64'h9999_8888_7777_6666;
    localparam logic [PW-1:0] WY = 64'h5A5A_4B4B_3C3C_2D2D;

    initial begin
        logic exp_wo [6];

        nreset    = 1'b0;
        m_valid   = 1'b0; m_data = '0; m_frame = '0; m_wait_in = 1'b0;
        v_valid   = 1'b0; v_data = '0; v_frame = '0; v_wait_in = 1'b1;
        s_valid   = 1'b0; s_data = '0; s_frame = '0; s_wait_in = 1'b0;

        // Single word, back-to-back stream, idle gap, then another word.
        tbl.push_back(mk(0, '0, 4'b0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(1, WS, 4'b0001, 16'h1111, 1, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h2222, 0, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h3333, 0, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h4444, 0, 1, 1));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(1, WA, 4'b1001, 16'hA0A0, 1, 1, 0));
        tbl.push_back(mk(1, WA, 4'b1001, 16'hA1A1, 0, 1, 0));
        tbl.push_back(mk(1, WA, 4'b1001, 16'hA2A2, 0, 1, 0));
        tbl.push_back(mk(1, WA, 4'b1001, 16'hA3A3, 1, 1, 1));
        tbl.push_back(mk(1, WB, 4'b0110, 16'hB0B0, 0, 1, 0));
        tbl.push_back(mk(1, WB, 4'b0110, 16'hB1B1, 1, 1, 0));
        tbl.push_back(mk(1, WB, 4'b0110, 16'hB2B2, 1, 1, 0));
        tbl.push_back(mk(1, WB, 4'b0110, 16'hB3B3, 0, 1, 1));
        tbl.push_back(mk(1, WC, 4'b1010, 16'hC0C0, 0, 1, 0));
        tbl.push_back(mk(1, WC, 4'b1010, 16'hC1C1, 1, 1, 0));
        tbl.push_back(mk(1, WC, 4'b1010, 16'hC2C2, 0, 1, 0));
        tbl.push_back(mk(1, WC, 4'b1010, 16'hC3C3, 1, 1, 1));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(1, WD, 4'b1111, 16'h1008, 1, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h2004, 1, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h4002, 1, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h8001, 1, 1, 1));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(1, WE, 4'b0100, 16'h0000, 0, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'hFFFF, 0, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h0000, 1, 1, 0));
        tbl.push_back(mk(0, '0, 4'b0000, 16'hFFFF, 0, 1, 1));
        tbl.push_back(mk(0, '0, 4'b0000, 16'h0000, 0, 0, 1));

        // Stall: wait pulse lands so wait_out rises with the final slice.
        stl.push_back(mks(0, 1, W0, 16'hD0D0, 1, 0, 0));
        stl.push_back(mks(1, 1, W1, 16'hD1D1, 1, 0, 0));
        stl.push_back(mks(0, 1, W1, 16'hD2D2, 1, 0, 0));
        stl.push_back(mks(0, 1, W1, 16'hD3D3, 1, 0, 1));
        stl.push_back(mks(0, 1, W1, 16'h0000, 0, 0, 1));
        stl.push_back(mks(0, 1, W1, 16'h0000, 0, 1, 0));
        stl.push_back(mks(0, 1, W1, 16'hE0E0, 1, 0, 0));
        stl.push_back(mks(0, 0, '0, 16'hE1E1, 1, 0, 0));
        stl.push_back(mks(0, 0, '0, 16'hE2E2, 1, 0, 0));
        stl.push_back(mks(0, 0, '0, 16'hE3E3, 1, 1, 0));
        stl.push_back(mks(0, 0, '0, 16'h0000, 0, 1, 0));

        @(negedge clk);

        // ---- Reset and idle ----
        for (int i = 0; i < 3; i++) begin
            step();
            chk_main($sformatf("reset%0d", i), 16'h0000, 0, 0, 1);
            chk($sformatf("reset%0d wait_out", i), 64'(m_wait_out), 64'd0);
            chk($sformatf("reset%0d inv out_data", i), 64'(v_odata), 64'hFFFF);
            chk($sformatf("reset%0d inv out_frame", i), 64'(v_oframe), 64'd1);
            chk($sformatf("reset%0d inv wait_out", i), 64'(v_wait_out), 64'd0);
        end
        nreset = 1'b1;
        step();
        chk_main("release", 16'h0000, 0, 0, 1);
        chk("release wait_out", 64'(m_wait_out), 64'd0);

        // ---- Table-driven vectors on the main instance ----
        for (int i = 0; i < tbl.size(); i++) begin
            m_valid = tbl[i].valid;
            m_data  = tbl[i].data;
            m_frame = tbl[i].frame;
            step();
            chk_main($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_frame,
                     tbl[i].e_busy, tbl[i].e_ready);
        end
        m_valid = 1'b0;

        // ---- Wait stretch: one-cycle pulse, WAITHOLD=2 ----
        exp_wo[0] = 0; exp_wo[1] = 0; exp_wo[2] = 1;
        exp_wo[3] = 1; exp_wo[4] = 0; exp_wo[5] = 0;
        m_wait_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            m_wait_in = 1'b0;
            chk($sformatf("stretch%0d wait_out", i), 64'(m_wait_out), 64'(exp_wo[i]));
            $display("stretch%0d: wait_out=%0b", i, m_wait_out);
        end

        // ---- Inverted pins: wait_in held 1 reads as no wait ----
        chk("inv wait_out", 64'(v_wait_out), 64'd0);
        chk("inv idle out_data", 64'(v_odata), 64'hFFFF);
        v_valid = 1'b1; v_data = WS; v_frame = 4'b0001;
        step();
        v_valid = 1'b0;
        chk("inv s0 out_data", 64'(v_odata), 64'hEEEE);
        chk("inv s0 out_frame", 64'(v_oframe), 64'd0);
        step();
        chk("inv s1 out_data", 64'(v_odata), 64'hDDDD);
        chk("inv s1 out_frame", 64'(v_oframe), 64'd1);
        step(); step();
        chk("inv s3 out_data", 64'(v_odata), 64'hBBBB);
        step();
        chk("inv idle2 out_data", 64'(v_odata), 64'hFFFF);
        chk("inv idle2 out_busy", 64'(v_obusy), 64'd0);
        chk("inv held wait_out", 64'(v_wait_out), 64'd0);
        $display("inv: data=%h frame=%0b wait_out=%0b", v_odata, v_oframe, v_wait_out);

        // ---- Stall sequence ----
        for (int i = 0; i < stl.size(); i++) begin
            s_wait_in = stl[i].wait_in;
            s_valid   = stl[i].valid;
            s_data    = stl[i].data;
            s_frame   = 4'b0000;
            step();
            chk($sformatf("stall%0d out_data", i), 64'(s_odata), 64'(stl[i].e_data));
            chk($sformatf("stall%0d out_busy", i), 64'(s_obusy), 64'(stl[i].e_busy));
            chk($sformatf("stall%0d in_ready", i), 64'(s_ready), 64'(stl[i].e_ready));
            chk($sformatf("stall%0d wait_out", i), 64'(s_wait_out), 64'(stl[i].e_wait));
            $display("stall%0d: data=%h busy=%0b ready=%0b wait_out=%0b",
                     i, s_odata, s_obusy, s_ready, s_wait_out);
        end

        // ---- Reset mid-word ----
        m_valid = 1'b1; m_data = WX; m_frame = 4'b0011;
        step();
        m_valid = 1'b0;
        chk_main("midrst s0", 16'h6666, 1, 1, 0);
        step();
        chk_main("midrst s1", 16'h7777, 1, 1, 0);
        nreset = 1'b0;
        step();
        chk_main("midrst rst0", 16'h0000, 0, 0, 1);
        step();
        chk_main("midrst rst1", 16'h0000, 0, 0, 1);
        nreset = 1'b1;
        step();
        chk_main("midrst rel", 16'h0000, 0, 0, 1);
        m_valid = 1'b1; m_data = WY; m_frame = 4'b0100;
        step();
        m_valid = 1'b0;
        chk_main("after s0", 16'h2D2D, 0, 1, 0);
        step();
        chk_main("after s1", 16'h3C3C, 0, 1, 0);
        step();
        chk_main("after s2", 16'h4B4B, 1, 1, 0);
        step();
        chk_main("after s3", 16'h5A5A, 0, 1, 1);
        step();
        chk_main("after idle", 16'h0000, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/etx_gearbox.md
# etx_gearbox

Parametrised transmit gearbox for the eLink TX path. Accepts wide words with per-slice frame bits over a valid/ready handshake and emits them as gapless NW-bit slices, one per clock, with a matching frame bit, ready for DDR output registers. It also conditions the raw pushback wait input: synchronize, optional polarity inversion, minimum-width stretch. Optionally, it stalls word acceptance while wait is high. It sits between the TX protocol/arbiter logic and the IO primitives, and runs on a single fast clock.

## Interface
- PW, 64: input word width; must be an integer multiple of NW.
- NW, 16: output slice width per clock.
- R, PW/NW: slices per word (derived); must be ≥2.
- WAITHOLD, 2: minimum wait_out pulse width in cycles; must be ≥1.
- INVERT, 0: 1 = pins inverted (64-core board); XORs out_data, out_frame and wait_in.
- STALL, 0: 1 = in_ready is forced low while wait_out is high.

- clk  in  1  fast transmit clock
- nreset  in  1  reset, synchronous, active-low
- in_valid  in  1  in_data/in_frame valid
- in_data  in  PW  word; slice i = in_data[i*NW +: NW]
- in_frame  in  R  in_frame[i] accompanies slice i
- in_ready  out  1  word accepted when in_valid & in_ready at rising clk
- out_data  out  NW  registered slice (after INVERT XOR)
- out_frame  out  1  registered frame (after INVERT XOR)
- out_busy  out  1  registered; high while out_data carries a slice
- wait_in  in  1  raw asynchronous pushback from pad buffer
- wait_out  out  1  synchronized, stretched wait

## Operation
- State: busy flag, slice counter cnt (clog2(R) bits), PW data shift register, R-bit frame shift register.
- in_ready = (~busy | cnt==R-1) & ~(STALL & wait_out). The last slice of one word overlaps acceptance of the next, which gives a gapless stream.
- Accept: data reg <= in_data; frame reg <= in_frame; cnt <= 0; busy <= 1. Registered outputs load slice 0 and in_frame[0] on the same edge.
- Shift (busy, no accept): cnt <= cnt+1; outputs take slice cnt+1 and frame bit cnt+1.
- End of word: cnt==R-1 with no accept. Then busy <= 0, cnt <= 0, out_data <= 0^INVERT, out_frame <= 0^INVERT.
- Idle (busy=0, no accept): outputs hold their idle value 0^INVERT, replicated.
- Wait path: s1 <= wait_in; s2 <= s1; hist <= {hist[WAITHOLD-2:0], s2^INVERT} (WAITHOLD=1: a single register). wait_out = |hist.
- Wait never truncates a word in progress. STALL only blocks the next acceptance.

## Timing
- Reset (nreset low at a rising edge) gives, after that edge:
  - busy=0, cnt=0, out_busy=0, in_ready=1.
  - out_data={NW{INVERT}}, out_frame=INVERT.
  - s1=s2=0 and hist=0, so wait_out=0.
- Reset mid-word discards the word. No remaining slices are emitted.
- Latency: a word accepted at edge k drives slice i on out_data from edge k+i until edge k+i+1.
- Throughput: one word per R cycles when in_valid is held high. out_busy stays high continuously.
- A gap of m idle input cycles after a word yields m idle output cycles.
- wait_in rising before edge e gives wait_out high after edge e+2.
- A wait_in pulse of width w≥1 sampled high gives a wait_out pulse of w+WAITHOLD-1 cycles.
- Simultaneous events:
  - wait_out rising on the same edge as the final slice with STALL=1: in_ready drops on that cycle and the next word waits.
  - in_valid low at cnt==R-1: the block goes idle cleanly.

## Test plan
- Reset and idle: with PW=64, NW=16, INVERT=0, hold nreset low for 3 cycles and then release with in_valid=0. Require out_data=0, out_frame=0, out_busy=0, in_ready=1 and wait_out=0 throughout.
- Single word: present in_data=0x4444_3333_2222_1111 with in_frame=4'b0001 at edge k. Require out_data=0x1111, 0x2222, 0x3333, 0x4444 at edges k..k+3, out_frame=1,0,0,0, then idle 0 from k+4.
- Back-to-back: stream 3 words with in_valid held high. Require 12 consecutive slices with no gap, in_ready high only on cnt==3 cycles after the first accept, and out_busy continuously 1.
- Wait stretch: with WAITHOLD=2, send a 1-cycle wait_in pulse. Require wait_out high for exactly 2 cycles, starting 3 edges after the pulse. With INVERT=1 and wait_in held 1, require wait_out=0.
- Stall: with STALL=1, raise wait during the second slice of a word. Require that word to finish all 4 slices, in_ready to stay 0 until wait_out falls, and the next word's slice 0 on the edge after acceptance.
- Reset mid-word: assert nreset low at the edge after slice 1. Require idle outputs and out_busy=0 on the next edge with no further slices. After release, a new word serializes normally.
